// File: rtl/reg_bank_write_arbiter_pkg.sv
// Shared encodings and defaults for the register-bank write arbiter.
package reg_bank_write_arbiter_pkg;

    // Arbiter FSM state encodings
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWrite = 2'd1;
    localparam logic [1:0] StClear = 2'd2;

    // Default geometry
    localparam int unsigned DefWordSize = 16;
    localparam int unsigned DefNumReq   = 3;
    localparam int unsigned DefNumRegs  = 8;
    localparam int unsigned DefAddrW    = 3;

    // Width of a requester index; never below one bit so a single requester still elaborates
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_bank_write_arbiter_rr_picker.sv
// Combinational round-robin select: first set request at or above the pointer, wrapping.
module reg_bank_write_arbiter_rr_picker
    import reg_bank_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned PTR_W   = ptr_width(DefNumReq)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] winner_o,
    output logic               valid_o
);

    // Scan upward from the pointer first, then wrap to the indices below it
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (!valid_o && req_i[j] && (j >= int'(rr_ptr_i))) begin
                winner_o[j] = 1'b1;
                valid_o     = 1'b1;
            end
        end
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (!valid_o && req_i[j] && (j < int'(rr_ptr_i))) begin
                winner_o[j] = 1'b1;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin arbiter for the write port of a register bank, plus a one-register-per-cycle
// clear sweep. All outputs are registered.
module reg_bank_write_arbiter
    import reg_bank_write_arbiter_pkg::*;
#(
    parameter int unsigned WORD_SIZE = DefWordSize,
    parameter int unsigned NUM_REQ   = DefNumReq,
    parameter int unsigned NUM_REGS  = DefNumRegs,
    parameter int unsigned ADDR_W    = DefAddrW
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   req_data,
    input  logic                           clear_req,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REGS-1:0]            reg_load,
    output logic [NUM_REGS-1:0]            reg_clear,
    output logic [WORD_SIZE-1:0]           reg_data,
    output logic                           busy,
    output logic                           clear_done
);

    localparam int unsigned PtrW = ptr_width(NUM_REQ);

    logic [1:0]           state_q, state_d;
    logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]    clr_idx_q, clr_idx_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REGS-1:0]  reg_load_q, reg_load_d;
    logic [NUM_REGS-1:0]  reg_clear_q, reg_clear_d;
    logic [WORD_SIZE-1:0] reg_data_q, reg_data_d;
    logic                 busy_q, busy_d;
    logic                 clear_done_q, clear_done_d;

    logic [NUM_REQ-1:0]   winner;
    logic                 winner_valid;
    logic [ADDR_W-1:0]    win_addr;
    logic [WORD_SIZE-1:0] win_data;
    logic [PtrW-1:0]      win_idx;
    logic [ADDR_W-1:0]    clr_next;
    logic [NUM_REGS-1:0]  load_dec;
    logic [NUM_REGS-1:0]  clr_dec;

    reg_bank_write_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PtrW)
    ) u_rr_picker (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (winner),
        .valid_o  (winner_valid)
    );

    // Select the winner's address and data and recover its index
    always_comb begin
        win_addr = '0;
        win_data = '0;
        win_idx  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (winner[i]) begin
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
                win_data = req_data[i*WORD_SIZE +: WORD_SIZE];
                win_idx  = PtrW'(i);
            end
        end
    end

    // Register index the sweep shows next: 0 when starting from IDLE
    assign clr_next = (state_q == StClear) ? clr_idx_q + 1'b1 : '0;

    // One-hot decodes; an out-of-range address decodes to all zeros
    always_comb begin
        load_dec = '0;
        clr_dec  = '0;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            load_dec[r] = (int'(win_addr) == r);
            clr_dec[r]  = (int'(clr_next) == r);
        end
    end

    // FSM next state and next registered outputs
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        clr_idx_d    = clr_idx_q;
        grant_d      = '0;
        reg_load_d   = '0;
        reg_clear_d  = '0;
        reg_data_d   = reg_data_q;
        busy_d       = 1'b0;
        clear_done_d = 1'b0;
        case (state_q)
            StIdle: begin
                // A clear request beats any pending write
                if (clear_req) begin
                    state_d     = StClear;
                    clr_idx_d   = clr_next;
                    reg_clear_d = clr_dec;
                    busy_d      = 1'b1;
                end else if (winner_valid) begin
                    state_d    = StWrite;
                    grant_d    = winner;
                    reg_load_d = load_dec;
                    reg_data_d = win_data;
                    busy_d     = 1'b1;
                    // Pointer only matters in IDLE, so advancing it now is equivalent
                    if (32'(win_idx) + 32'd1 >= NUM_REQ) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = win_idx + 1'b1;
                    end
                end
            end
            StWrite: begin
                // Mandatory IDLE cycle so a held req cannot be granted twice
                state_d = StIdle;
            end
            StClear: begin
                if (clr_idx_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d      = StIdle;
                    clr_idx_d    = '0;
                    clear_done_d = 1'b1;
                end else begin
                    clr_idx_d   = clr_next;
                    reg_clear_d = clr_dec;
                    busy_d      = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            clr_idx_q    <= '0;
            grant_q      <= '0;
            reg_load_q   <= '0;
            reg_clear_q  <= '0;
            reg_data_q   <= '0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            clr_idx_q    <= clr_idx_d;
            grant_q      <= grant_d;
            reg_load_q   <= reg_load_d;
            reg_clear_q  <= reg_clear_d;
            reg_data_q   <= reg_data_d;
            busy_q       <= busy_d;
            clear_done_q <= clear_done_d;
        end
    end

    assign grant      = grant_q;
    assign reg_load   = reg_load_q;
    assign reg_clear  = reg_clear_q;
    assign reg_data   = reg_data_q;
    assign busy       = busy_q;
    assign clear_done = clear_done_q;

endmodule
